hps_cfg_decoder: RTL and testbench
==================================

HPS_CFG_DECODER -- requirements
Module: hps_cfg_decoder

Interface
REQ-001 Parameter CMD_ID, default 8'h01: command byte selecting this decoder.
REQ-002 Parameter NUM_WORDS, default 4, range 1..16: number of 16-bit config words held.
REQ-003 Port clk_sys  input  1: sole clock; all logic on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port io_uio  input  1: user-I/O transaction enable; high for the duration of one transaction.
REQ-006 Port io_strobe  input  1: HPS data strobe; each 0->1 transition carries one word.
REQ-007 Port io_din  input  16: HPS data word; sampled on the strobe edge.
REQ-008 Port cfg  output  NUM_WORDS*16: config words, word k at bits [16k+15:16k].
REQ-009 Port cfg_ready  output  1: sticky; high once any config word has taken effect.
REQ-010 Port cfg_update  output  1: one-cycle pulse when cfg changes.
REQ-011 Port cmd_ovf  output  1: words beyond NUM_WORDS were received in the current or last transaction.

Function
REQ-012 Strobe edge = io_strobe high AND registered previous io_strobe low; only edges advance the FSM.
REQ-013 States: SYNC, IDLE, CMD, DATA, SKIP.
REQ-014 SYNC: entered on reset; moves to IDLE only after io_uio is sampled low, so a transaction already in progress is ignored.
REQ-015 IDLE: io_uio high -> CMD; word index cleared; cmd_ovf cleared.
REQ-016 CMD: on a strobe edge, io_din[7:0]==CMD_ID -> DATA, otherwise -> SKIP.
REQ-017 DATA: each strobe edge writes io_din to word[index], then index+1.
REQ-018 DATA: when index reaches NUM_WORDS -> SKIP; the index saturates and never wraps.
REQ-019 A strobe edge in SKIP, after the word limit was reached in this transaction, sets cmd_ovf; data is discarded.
REQ-020 SKIP: strobe edges after a foreign command are ignored; cmd_ovf stays 0.
REQ-021 io_uio low in CMD/DATA/SKIP -> IDLE next cycle.
REQ-022 io_uio low overrides a simultaneous strobe edge: that word is not written.
REQ-023 Latency: strobe edge sampled at cycle N -> cfg visible at N+1 (non-shadow).
REQ-024 Latency: cfg_update asserted at N+1, for exactly one cycle.
REQ-025 Back-to-back strobe edges (every other cycle) are each accepted.

Reset
REQ-026 On reset: cfg=0, cfg_ready=0, cfg_update=0, cmd_ovf=0, index=0, state=SYNC.
REQ-027 Reset asserted mid-transaction aborts it; no partial commit occurs.

Configuration
REQ-028 Macro CFG_SHADOW_EN selects the update mode.
REQ-029 Macro defined: words write a shadow register loaded from cfg on IDLE->CMD.
REQ-030 Macro defined: shadow is copied to cfg in the cycle after io_uio is sampled low, only if at least one DATA word was written.
REQ-031 Macro defined: cfg_update and cfg_ready assert with that copy; cfg never shows a partially written set.
REQ-032 Macro undefined: no shadow register; per-word update as in REQ-023/REQ-024; cfg_ready sets with the first word written.

Verification
REQ-033 Reset, uio=1, strobes 0x0001,0x1234,0xABCD, uio=0 -> cfg[15:0]=0x1234, cfg[31:16]=0xABCD, others 0, cfg_ready=1, cmd_ovf=0.
REQ-034 Command 0x0002 then 0x5555 (CMD_ID=1) -> cfg unchanged, no cfg_update, cmd_ovf=0.
REQ-035 NUM_WORDS=2, words 1,2,3 after cmd 0x0001 -> cfg={2,1}, cmd_ovf=1.
REQ-036 New transaction after REQ-035 -> cmd_ovf returns to 0.
REQ-037 Reset asserted while uio=1 and 2 words sent; uio held high with more strobes -> cfg stays 0 until uio goes low then a fresh transaction occurs.
REQ-038 CFG_SHADOW_EN: 3 words sent, uio still high -> cfg unchanged.
REQ-039 CFG_SHADOW_EN: uio low -> all 3 words appear in the same cycle with a single cfg_update pulse.

Source files
------------

// File: rtl/hps_cfg_decoder.sv
// hps_cfg_decoder: decodes HPS user-I/O transactions into NUM_WORDS
// 16-bit configuration words.
//
// Parameters
//   CMD_ID     command byte that selects this decoder
//   NUM_WORDS  number of 16-bit config words held (1..16)
//
// Ports
//   clk_sys     in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   io_uio      in   transaction enable, high for one whole transaction
//   io_strobe   in   data strobe, each 0->1 transition carries one word
//   io_din      in   16-bit data word, sampled on the strobe edge
//   cfg         out  config words, word k at [16k+15:16k]
//   cfg_ready   out  sticky, high once any config word has taken effect
//   cfg_update  out  one-cycle pulse whenever cfg changes
//   cmd_ovf     out  extra words arrived in the current/last transaction
//
// Build option
//   CFG_SHADOW_EN  defined: words collect in a shadow copy and are
//                  committed to cfg as a set when the transaction ends.
//                  undefined: each word lands in cfg as it arrives.
module hps_cfg_decoder #(
    parameter logic [7:0] CMD_ID    = 8'h01,
    parameter int         NUM_WORDS = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   io_uio,
    input  logic                   io_strobe,
    input  logic [15:0]            io_din,
    output logic [NUM_WORDS*16-1:0] cfg,
    output logic                   cfg_ready,
    output logic                   cfg_update,
    output logic                   cmd_ovf
);

    localparam int IW = 5;
    localparam logic [IW-1:0] LAST  = IW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] LIMIT = IW'(NUM_WORDS);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        CMD,
        DATA,
        SKIP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          strobe_q;
    logic          stb_edge;
    logic [IW-1:0] index;
    logic          limit_hit;

    logic          start;
    logic          wr;
    logic          ovf_set;
    logic          leave;

    assign stb_edge = io_strobe & ~strobe_q;

    // index parks at NUM_WORDS once the last word is taken, so reaching
    // it tells SKIP whether it came from a full DATA phase or a foreign
    // command.
    assign limit_hit = (index == LIMIT);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr        = 1'b0;
        ovf_set   = 1'b0;
        leave     = 1'b0;
        unique case (state)
            SYNC: begin
                // wait out any transaction already running at reset
                if (!io_uio) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (io_uio) begin
                    state_nxt = CMD;
                    start     = 1'b1;
                end
            end
            CMD: begin
                if (!io_uio) begin
                    state_nxt = IDLE;
                end else if (stb_edge) begin
                    state_nxt = (io_din[7:0] == CMD_ID) ? DATA : SKIP;
                end
            end
            DATA: begin
                // uio low wins over a coincident strobe edge
                if (!io_uio) begin
                    state_nxt = IDLE;
                    leave     = 1'b1;
                end else if (stb_edge) begin
                    wr = 1'b1;
                    if (index == LAST) begin
                        state_nxt = SKIP;
                    end
                end
            end
            SKIP: begin
                if (!io_uio) begin
                    state_nxt = IDLE;
                    leave     = 1'b1;
                end else if (stb_edge && limit_hit) begin
                    ovf_set = 1'b1;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

`ifdef CFG_SHADOW_EN
    logic [NUM_WORDS*16-1:0] shadow;
    logic                    dirty;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            index      <= '0;
            cmd_ovf    <= 1'b0;
            cfg        <= '0;
            cfg_ready  <= 1'b0;
            cfg_update <= 1'b0;
`ifdef CFG_SHADOW_EN
            shadow     <= '0;
            dirty      <= 1'b0;
`endif
        end else begin
            strobe_q   <= io_strobe;
            cfg_update <= 1'b0;
            if (start) begin
                index   <= '0;
                cmd_ovf <= 1'b0;
            end
            if (ovf_set) begin
                cmd_ovf <= 1'b1;
            end
            if (wr) begin
                index <= index + 1'b1;
            end
`ifdef CFG_SHADOW_EN
            // shadow starts from the live set so untouched words persist
            if (start) begin
                shadow <= cfg;
                dirty  <= 1'b0;
            end
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (wr && index == IW'(k)) begin
                    shadow[k*16 +: 16] <= io_din;
                end
            end
            if (wr) begin
                dirty <= 1'b1;
            end
            if (leave) begin
                dirty <= 1'b0;
                if (dirty) begin
                    cfg        <= shadow;
                    cfg_update <= 1'b1;
                    cfg_ready  <= 1'b1;
                end
            end
`else
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (wr && index == IW'(k)) begin
                    cfg[k*16 +: 16] <= io_din;
                end
            end
            if (wr) begin
                cfg_update <= 1'b1;
                cfg_ready  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hps_cfg_decoder.sv
// tb_hps_cfg_decoder: directed self-checking bench for hps_cfg_decoder,
// one instance with NUM_WORDS=4 and one with NUM_WORDS=2 on shared inputs.
module tb_hps_cfg_decoder;

`ifdef CFG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        io_uio;
    logic        io_strobe;
    logic [15:0] io_din;

    logic [63:0] cfg1;
    logic        ready1;
    logic        upd1;
    logic        ovf1;
    logic [31:0] cfg2;
    logic        ready2;
    logic        upd2;
    logic        ovf2;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int u0;

    always #5 clk_sys = ~clk_sys;

    hps_cfg_decoder #(.CMD_ID(8'h01), .NUM_WORDS(4)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .io_uio     (io_uio),
        .io_strobe  (io_strobe),
        .io_din     (io_din),
        .cfg        (cfg1),
        .cfg_ready  (ready1),
        .cfg_update (upd1),
        .cmd_ovf    (ovf1)
    );

    hps_cfg_decoder #(.CMD_ID(8'h01), .NUM_WORDS(2)) dut2 (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .io_uio     (io_uio),
        .io_strobe  (io_strobe),
        .io_din     (io_din),
        .cfg        (cfg2),
        .cfg_ready  (ready2),
        .cfg_update (upd2),
        .cmd_ovf    (ovf2)
    );

    always @(negedge clk_sys) begin
        if (upd1) upd_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        io_din    = w;
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        tick();
    endtask

    task automatic open_t;
        io_uio = 1'b1;
        tick();
    endtask

    task automatic close_t;
        io_uio = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        io_uio    = 1'b0;
        io_strobe = 1'b0;
        io_din    = 16'h0;
        tick();
        tick();
        tick();
        check("rst_cfg", cfg1, 64'h0);
        check("rst_ready", ready1, 1'b0);
        check("rst_upd", upd1, 1'b0);
        check("rst_ovf", ovf1, 1'b0);
        check("rst_cfg2", cfg2, 64'h0);
        reset = 1'b0;
        tick();
        tick();

        // basic transaction, per-word latency
        open_t();
        send(16'h0001);
        io_din    = 16'h1234;
        io_strobe = 1'b1;
        tick();
        check("lat_w0", cfg1[15:0], SHADOW ? 16'h0 : 16'h1234);
        check("lat_upd", upd1, SHADOW ? 1'b0 : 1'b1);
        io_strobe = 1'b0;
        tick();
        check("upd_pulse", upd1, 1'b0);
        send(16'hABCD);
        close_t();
        check("basic_cfg", cfg1, 64'h0000_0000_ABCD_1234);
        check("basic_ready", ready1, 1'b1);
        check("basic_ovf", ovf1, 1'b0);
        check("basic_cfg2", cfg2, 64'hABCD_1234);
        check("exact_ovf2", ovf2, 1'b0);

        // foreign command
        u0 = upd_cnt;
        open_t();
        send(16'h0002);
        send(16'h5555);
        close_t();
        check("foreign_cfg", cfg1, 64'h0000_0000_ABCD_1234);
        check("foreign_upd", upd_cnt, u0);
        check("foreign_ovf", ovf1, 1'b0);

        // overflow on the 2-word instance, index saturation
        open_t();
        send(16'h0001);
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        check("ovf_cur", ovf2, 1'b1);
        send(16'h0004);
        close_t();
        check("ovf_cfg2", cfg2, 64'h0002_0001);
        check("ovf_last", ovf2, 1'b1);
        check("full_cfg", cfg1, 64'h0004_0003_0002_0001);
        check("full_ovf", ovf1, 1'b0);

        // overflow clears on the next transaction
        open_t();
        check("ovf_clr", ovf2, 1'b0);
        send(16'h0002);
        send(16'h0007);
        close_t();
        check("ovf_foreign", ovf2, 1'b0);

        // uio low beats a coincident strobe edge
        open_t();
        send(16'h0001);
        send(16'h1111);
        io_din    = 16'h2222;
        io_uio    = 1'b0;
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        tick();
        tick();
        check("uio_win", cfg1, 64'h0004_0003_0002_1111);
        check("uio_win2", cfg2, 64'h0002_1111);

        // a held strobe counts once
        open_t();
        send(16'h0001);
        io_din    = 16'h0D0D;
        io_strobe = 1'b1;
        tick();
        tick();
        tick();
        io_strobe = 1'b0;
        tick();
        send(16'h0E0E);
        close_t();
        check("hold_cfg", cfg1, 64'h0004_0003_0E0E_0D0D);

        // reset mid-transaction, then SYNC ignores the rest
        open_t();
        send(16'h0001);
        send(16'h7777);
        send(16'h8888);
        reset = 1'b1;
        tick();
        tick();
        check("mid_rst_cfg", cfg1, 64'h0);
        check("mid_rst_rdy", ready1, 1'b0);
        reset = 1'b0;
        u0 = upd_cnt;
        send(16'h0001);
        send(16'h9999);
        send(16'h0005);
        check("sync_cfg", cfg1, 64'h0);
        check("sync_rdy", ready1, 1'b0);
        check("sync_upd", upd_cnt, u0);
        close_t();
        check("sync_close", cfg1, 64'h0);
        open_t();
        send(16'h0001);
        send(16'h4242);
        close_t();
        check("fresh_cfg", cfg1, 64'h0000_0000_0000_4242);
        check("fresh_rdy", ready1, 1'b1);
        check("fresh_cfg2", cfg2, 64'h0000_4242);

        // set commit: shadow holds back until uio drops
        u0 = upd_cnt;
        open_t();
        send(16'h0001);
        send(16'h00A1);
        send(16'h00B2);
        send(16'h00C3);
        check("set_hold", cfg1,
              SHADOW ? 64'h0000_0000_0000_4242 : 64'h0000_00C3_00B2_00A1);
        check("set_hold_upd", upd_cnt, SHADOW ? u0 : u0 + 3);
        io_uio = 1'b0;
        tick();
        check("set_commit", cfg1, 64'h0000_00C3_00B2_00A1);
        check("set_upd", upd1, SHADOW ? 1'b1 : 1'b0);
        tick();
        check("set_upd_end", upd1, 1'b0);
        check("set_upd_cnt", upd_cnt, SHADOW ? u0 + 1 : u0 + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
